// File: rtl/masked_and_xor_pipe.sv
// Two-stage domain-oriented masked q = (x' & y) ^ z over SHARES Boolean shares.
// Stage 1 registers every refreshed share product, stage 2 registers the compressed shares.
module masked_and_xor_pipe #(
  parameter  int unsigned SHARES = 2,
  parameter  int unsigned WIDTH  = 5,
  parameter  bit          INVERT = 1'b1,
  localparam int unsigned RW     = WIDTH*SHARES*(SHARES-1)/2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     add_linear,
  input  logic [SHARES*WIDTH-1:0]  x,
  input  logic [SHARES*WIDTH-1:0]  y,
  input  logic [SHARES*WIDTH-1:0]  z,
  input  logic [RW-1:0]            r,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SHARES*WIDTH-1:0]  q
);

  logic [WIDTH-1:0]        t_d [SHARES][SHARES];
  logic [WIDTH-1:0]        t_q [SHARES][SHARES];
  logic [SHARES*WIDTH-1:0] q_d, q_q;
  logic                    s1_valid_q, s2_valid_q;
  logic                    s1_adv, s2_adv;

  // Index of unordered pair (a<b) in lexicographic order (0,1),(0,2)..(1,2)..
  function automatic int unsigned pair_idx(input int unsigned a, input int unsigned b);
    return (a * (2*SHARES - a - 1)) / 2 + (b - a - 1);
  endfunction

  assign s2_adv    = ~s2_valid_q | out_ready;
  assign s1_adv    = ~s1_valid_q | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign q         = q_q;

  always_comb begin
    logic [WIDTH-1:0] xs;
    int unsigned      p;
    t_d = '{default: '0};
    for (int unsigned i = 0; i < SHARES; i++) begin
      xs = x[i*WIDTH +: WIDTH];
      if (i == 0 && INVERT) xs = ~xs;
      for (int unsigned j = 0; j < SHARES; j++) begin
        if (i == j) begin
          t_d[i][j] = (xs & y[j*WIDTH +: WIDTH]) ^ (add_linear ? z[i*WIDTH +: WIDTH] : '0);
        end else begin
          p = (i < j) ? pair_idx(i, j) : pair_idx(j, i);
          t_d[i][j] = (xs & y[j*WIDTH +: WIDTH]) ^ r[p*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Compression only reads registered products, so no glitch path spans domains.
  always_comb begin
    q_d = '0;
    for (int unsigned i = 0; i < SHARES; i++) begin
      for (int unsigned j = 0; j < SHARES; j++) begin
        q_d[i*WIDTH +: WIDTH] = q_d[i*WIDTH +: WIDTH] ^ t_q[i][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      t_q        <= '{default: '0};
      q_q        <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) t_q <= t_d;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) q_q <= q_d;
      end
    end
  end

endmodule

// File: tb/tb_masked_and_xor_pipe.sv
// Bench for masked_and_xor_pipe: 2-share scoreboarded pipeline checks plus a 3-share instance.
module tb_masked_and_xor_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, add_linear, out_valid, out_ready;
  logic [9:0]  x, y, z, q;
  logic [4:0]  r;
  logic        in_valid3, in_ready3, add3, out_valid3, out_ready3;
  logic [14:0] x3, y3, z3, q3, r3;

  masked_and_xor_pipe #(.SHARES(2), .WIDTH(5), .INVERT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .add_linear(add_linear), .x(x), .y(y), .z(z), .r(r),
    .out_valid(out_valid), .out_ready(out_ready), .q(q)
  );

  masked_and_xor_pipe #(.SHARES(3), .WIDTH(5), .INVERT(1'b0)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .add_linear(add3), .x(x3), .y(y3), .z(z3), .r(r3),
    .out_valid(out_valid3), .out_ready(out_ready3), .q(q3)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_out  = 0;
  int first_cyc = -1;
  int last_cyc  = -1;
  always @(posedge clk) cyc++;

  typedef struct { logic [9:0] q; logic [4:0] u; } exp_t;
  exp_t sb[$];
  logic [4:0] cur_u;

  typedef struct {
    logic [4:0] X, Y, Z, mx, my, mz, rr;
    logic       add;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected shares for 2 shares, share 0 of x complemented.
  function automatic logic [9:0] model2(input logic [9:0] xs, ys, zs, input logic [4:0] rr,
                                        input logic add);
    logic [4:0] x0, x1, y0, y1, z0, z1;
    x0 = ~xs[4:0]; x1 = xs[9:5];
    y0 = ys[4:0];  y1 = ys[9:5];
    z0 = add ? zs[4:0] : 5'b0;
    z1 = add ? zs[9:5] : 5'b0;
    return {(x1 & y1) ^ z1 ^ (x1 & y0) ^ rr, (x0 & y0) ^ z0 ^ (x0 & y1) ^ rr};
  endfunction

  // Expected shares for 3 shares, no inversion; pairs (0,1),(0,2),(1,2) -> r slices 0,1,2.
  function automatic logic [14:0] model3(input logic [14:0] xs, ys, zs, rr, input logic add);
    logic [4:0]  rp [3][3];
    logic [4:0]  acc;
    logic [14:0] res;
    rp[0][1] = rr[4:0];   rp[1][0] = rr[4:0];
    rp[0][2] = rr[9:5];   rp[2][0] = rr[9:5];
    rp[1][2] = rr[14:10]; rp[2][1] = rr[14:10];
    rp[0][0] = 5'b0; rp[1][1] = 5'b0; rp[2][2] = 5'b0;
    res = '0;
    for (int i = 0; i < 3; i++) begin
      acc = (xs[i*5 +: 5] & ys[i*5 +: 5]) ^ (add ? zs[i*5 +: 5] : 5'b0);
      for (int j = 0; j < 3; j++)
        if (j != i) acc = acc ^ (xs[i*5 +: 5] & ys[j*5 +: 5]) ^ rp[i][j];
      res[i*5 +: 5] = acc;
    end
    return res;
  endfunction

  // Scoreboard: push on accept, pop on output handoff.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        n_out++;
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_output: got q=%h with empty scoreboard", q);
        end else begin
          e = sb.pop_front();
          chk("q_shares", q, e.q);
          chk("q_unmasked", q[4:0] ^ q[9:5], e.u);
        end
      end
      if (in_valid && in_ready) begin
        e.q = model2(x, y, z, r, add_linear);
        e.u = cur_u;
        sb.push_back(e);
      end
    end
  end

  task automatic drive_vec(input logic [4:0] X, Y, Z, mx, my, mz, rr, input logic add,
                           input logic [4:0] u);
    x = {X ^ mx, mx};
    y = {Y ^ my, my};
    z = {Z ^ mz, mz};
    r = rr;
    add_linear = add;
    cur_u = u;
    in_valid = 1'b1;
  endtask

  task automatic drive_rand(input logic add);
    logic [4:0] X, Y, Z;
    X = 5'($urandom); Y = 5'($urandom); Z = 5'($urandom);
    drive_vec(X, Y, Z, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), add,
              (~X & Y) ^ (add ? Z : 5'b0));
  endtask

  // Returns just after the accepting edge; stalls = negedges seen with in_ready low.
  task automatic wait_accept(output int stalls);
    stalls = 0;
    @(negedge clk);
    while (!in_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $fatal(1);
  end

  initial begin
    int st, lat, n0, stot;
    logic [9:0]  snap;
    logic [4:0]  X, Y, Z, m1, m2;
    logic        a;

    tbl[0] = '{5'b10110, 5'b01101, 5'b00011, 5'b00111, 5'b11010, 5'b01100, 5'b10101, 1'b1, 5'b01010};
    tbl[1] = '{5'b10110, 5'b01101, 5'b00011, 5'b00111, 5'b11010, 5'b01100, 5'b10101, 1'b0, 5'b01001};
    tbl[2] = '{5'b10110, 5'b01101, 5'b00011, 5'b00111, 5'b11010, 5'b01100, 5'b00000, 1'b0, 5'b01001};
    tbl[3] = '{5'b10110, 5'b01101, 5'b00011, 5'b00111, 5'b11010, 5'b01100, 5'b11111, 1'b0, 5'b01001};
    tbl[4] = '{5'b00000, 5'b11111, 5'b10101, 5'b01001, 5'b00110, 5'b11100, 5'b01011, 1'b1, 5'b01010};
    tbl[5] = '{5'b11111, 5'b11111, 5'b11111, 5'b10010, 5'b01111, 5'b00001, 5'b11000, 1'b1, 5'b11111};
    tbl[6] = '{5'b11111, 5'b11111, 5'b00000, 5'b01110, 5'b10001, 5'b10111, 5'b00110, 1'b0, 5'b00000};

    rst_n = 1'b0; in_valid = 1'b0; add_linear = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; z = '0; r = '0; cur_u = '0;
    in_valid3 = 1'b0; add3 = 1'b0; out_ready3 = 1'b1;
    x3 = '0; y3 = '0; z3 = '0; r3 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_q", 32'(q), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid3", 32'(out_valid3), 32'd0);
    @(posedge clk); #1;

    // Single transactions from the table: fixed latency, no stall.
    for (int i = 0; i < 7; i++) begin
      drive_vec(tbl[i].X, tbl[i].Y, tbl[i].Z, tbl[i].mx, tbl[i].my, tbl[i].mz,
                tbl[i].rr, tbl[i].add, tbl[i].exp);
      wait_accept(st);
      in_valid = 1'b0;
      chk("tbl_in_ready", st, 0);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!out_valid && lat < 10);
      chk("tbl_latency", lat, 2);
      @(posedge clk); #1;
    end
    repeat (3) @(negedge clk);
    chk("tbl_drained", sb.size(), 0);
    @(posedge clk); #1;

    // Back-to-back stream.
    n0 = n_out; first_cyc = -1; stot = 0;
    for (int i = 0; i < 8; i++) begin
      drive_rand(1'($urandom_range(1)));
      wait_accept(st);
      stot += st;
    end
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("stream_count", n_out - n0, 8);
    chk("stream_span", last_cyc - first_cyc, 7);
    chk("stream_no_stall", stot, 0);
    chk("stream_drained", sb.size(), 0);
    @(posedge clk); #1;

    // Backpressure: two accepts fill the pipe, third waits.
    out_ready = 1'b0;
    n0 = n_out;
    drive_rand(1'b1);
    wait_accept(st);
    drive_rand(1'b0);
    wait_accept(st);
    chk("bp_second_accept", st, 0);
    snap = q;
    drive_rand(1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_out_valid_held", 32'(out_valid), 32'd1);
      chk("bp_q_held", 32'(q), 32'(snap));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_accept(st);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("bp_out_count", n_out - n0, 3);
    chk("bp_drained", sb.size(), 0);
    @(posedge clk); #1;

    // Reset with both stages full.
    out_ready = 1'b0;
    drive_rand(1'b1);
    wait_accept(st);
    drive_rand(1'b1);
    wait_accept(st);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_pipe_full", 32'(out_valid), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_q", 32'(q), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    n0 = n_out;
    repeat (6) @(negedge clk);
    chk("midrst_no_stale", n_out - n0, 0);
    @(posedge clk); #1;

    // Three shares, no inversion.
    for (int i = 0; i < 20; i++) begin
      X = 5'($urandom); Y = 5'($urandom); Z = 5'($urandom); a = 1'($urandom_range(1));
      m1 = 5'($urandom); m2 = 5'($urandom); x3 = {X ^ m1 ^ m2, m2, m1};
      m1 = 5'($urandom); m2 = 5'($urandom); y3 = {Y ^ m1 ^ m2, m2, m1};
      m1 = 5'($urandom); m2 = 5'($urandom); z3 = {Z ^ m1 ^ m2, m2, m1};
      r3 = 15'($urandom); add3 = a; in_valid3 = 1'b1;
      st = 0;
      @(negedge clk);
      while (!in_ready3 && st < 20) begin st++; @(negedge clk); end
      @(posedge clk); #1 in_valid3 = 1'b0;
      st = 0;
      @(negedge clk);
      while (!out_valid3 && st < 20) begin st++; @(negedge clk); end
      chk("s3_out_valid", 32'(out_valid3), 32'd1);
      chk("s3_shares", 32'(q3), 32'(model3(x3, y3, z3, r3, a)));
      chk("s3_unmasked", 32'(q3[4:0] ^ q3[9:5] ^ q3[14:10]), 32'((X & Y) ^ (a ? Z : 5'b0)));
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
